// File: rtl/cyc_unshift.sv
// cyc_unshift: inverse LDPC cyclic shift. Pops an in-order shift tag and rotates each returning message left by k lanes.
// Latency: 1 cycle from message accept to out_valid. The result is held in a registered output stage.
// Backpressure: msg_ready drops when the tag FIFO is empty or the output stage is held. Optional CYC_UNSHIFT_BYPASS_EN.

module cyc_unshift_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_push,
  input  logic          i_pop,
  input  logic [W-1:0]  i_dat,
  output logic [W-1:0]  o_dat,
  output logic [AW:0]   o_cnt,
  output logic          o_full,
  output logic          o_empty
);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_cnt;
  logic          w_push_ok;
  logic          w_pop_ok;

  assign o_full    = (r_cnt == FULL_CNT);
  assign o_empty   = (r_cnt == '0);
  assign o_cnt     = r_cnt;
  assign o_dat     = r_mem[r_rd_ptr];
  // A full FIFO refuses a push even when the same cycle also pops.
  assign w_push_ok = i_push && !o_full;
  assign w_pop_ok  = i_pop && !o_empty;

  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= i_dat;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end
endmodule

module cyc_unshift #(
  parameter int data_w     = 8,
  parameter int D          = 5,
  parameter int FIFO_DEPTH = 16,
  parameter int AW         = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                sh_valid,
  output logic                sh_ready,
  input  logic [data_w-1:0]   shift,
  input  logic                msg_valid,
  output logic                msg_ready,
  input  logic [data_w*D-1:0] msg_in,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [data_w*D-1:0] out_msg,
  output logic                out_null,
  output logic                err_range,
  output logic [AW:0]         fifo_cnt
);
  localparam int                 MW    = data_w * D;
  localparam logic [data_w-1:0]  LANES = data_w'(D);

  logic              w_stage_free;
  logic              w_empty;
  logic              w_full;
  logic              w_bypass;
  logic              w_accept;
  logic              w_push;
  logic              w_pop;
  logic [data_w-1:0] w_head;
  logic [data_w-1:0] w_tag;
  logic [data_w-1:0] w_k;
  logic              w_null;
  logic              w_range;
  logic [MW-1:0]     w_rot;

  logic              r_out_valid;
  logic [MW-1:0]     r_out_msg;
  logic              r_out_null;
  logic              r_err_range;

  assign w_stage_free = !r_out_valid || out_ready;

`ifdef CYC_UNSHIFT_BYPASS_EN
  // Empty FIFO with both sides presenting: use the incoming shift directly.
  assign w_bypass = w_empty && sh_valid && msg_valid && w_stage_free;
`else
  assign w_bypass = 1'b0;
`endif

  assign sh_ready  = !w_full;
  assign msg_ready = (!w_empty || w_bypass) && w_stage_free;
  assign w_accept  = msg_valid && msg_ready;
  assign w_push    = sh_valid && sh_ready && !w_bypass;
  assign w_pop     = w_accept && !w_bypass;

  assign w_tag   = w_bypass ? shift : w_head;
  assign w_k     = w_tag >> 2;
  assign w_null  = &w_tag;
  assign w_range = !w_null && (w_k >= LANES);

  cyc_unshift_fifo #(
    .W     (data_w),
    .DEPTH (FIFO_DEPTH),
    .AW    (AW)
  ) u_tag_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_dat   (shift),
    .o_dat   (w_head),
    .o_cnt   (fifo_cnt),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // Output lane i takes input lane (i - k) mod D, i.e. a left rotation by k lanes.
  always_comb begin
    int kl;
    int idx;
    w_rot = '0;
    kl    = 0;
    idx   = 0;
    if (!w_null && !w_range) kl = int'(w_k);
    for (int i = 0; i < D; i++) begin
      idx = i + D - kl;
      if (idx >= D) idx = idx - D;
      w_rot[i*data_w +: data_w] = msg_in[idx*data_w +: data_w];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_msg   <= '0;
      r_out_null  <= 1'b0;
      r_err_range <= 1'b0;
    end else begin
      r_err_range <= w_accept && w_range;
      if (w_accept) begin
        r_out_valid <= 1'b1;
        r_out_null  <= w_null || w_range;
        r_out_msg   <= (w_null || w_range) ? '0 : w_rot;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_msg   = r_out_msg;
  assign out_null  = r_out_null;
  assign err_range = r_err_range;
endmodule

// File: tb/tb_cyc_unshift.sv
// Directed bench for cyc_unshift: rotation, null/range tags, full/empty, backpressure, async reset, bypass.
module tb_cyc_unshift;
  logic        clk;
  logic        rst_n;
  logic        sh_valid;
  logic        sh_ready;
  logic [7:0]  shift;
  logic        msg_valid;
  logic        msg_ready;
  logic [39:0] msg_in;
  logic        out_valid;
  logic        out_ready;
  logic [39:0] out_msg;
  logic        out_null;
  logic        err_range;
  logic [4:0]  fifo_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  cyc_unshift dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sh_valid  (sh_valid),
    .sh_ready  (sh_ready),
    .shift     (shift),
    .msg_valid (msg_valid),
    .msg_ready (msg_ready),
    .msg_in    (msg_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_msg   (out_msg),
    .out_null  (out_null),
    .err_range (err_range),
    .fifo_cnt  (fifo_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_tag(input logic [7:0] s);
    sh_valid = 1'b1;
    shift    = s;
    step();
    sh_valid = 1'b0;
  endtask

  logic [39:0] exp_drain [4];
  logic [39:0] held;

  initial begin
    exp_drain[0] = 40'h0403020105;
    exp_drain[1] = 40'h0302010504;
    exp_drain[2] = 40'h0201050403;
    exp_drain[3] = 40'h0105040302;

    rst_n = 1'b0; sh_valid = 1'b0; shift = '0; msg_valid = 1'b0;
    msg_in = '0; out_ready = 1'b1;
    #12;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_msg",   64'(out_msg),   64'd0);
    chk("rst_out_null",  64'(out_null),  64'd0);
    chk("rst_err_range", 64'(err_range), 64'd0);
    chk("rst_fifo_cnt",  64'(fifo_cnt),  64'd0);
    chk("rst_sh_ready",  64'(sh_ready),  64'd1);
    chk("rst_msg_ready", 64'(msg_ready), 64'd0);
    rst_n = 1'b1;
    step();

    // Basic rotation k=2
    push_tag(8'h08);
    chk("rot_cnt1", 64'(fifo_cnt), 64'd1);
    msg_valid = 1'b1; msg_in = 40'h1413121110;
    #1 chk("rot_msg_ready", 64'(msg_ready), 64'd1);
    step();
    msg_valid = 1'b0;
    chk("rot_out_valid", 64'(out_valid), 64'd1);
    chk("rot_out_msg",   64'(out_msg),   64'h1211101413);
    chk("rot_out_null",  64'(out_null),  64'd0);
    chk("rot_cnt0",      64'(fifo_cnt),  64'd0);

    // Null, range, identity
    push_tag(8'hFF); push_tag(8'h14); push_tag(8'h03);
    chk("nr_cnt3", 64'(fifo_cnt), 64'd3);
    msg_valid = 1'b1; msg_in = 40'hAABBCCDDEE;
    step();
    chk("null_msg",  64'(out_msg),   64'd0);
    chk("null_flag", 64'(out_null),  64'd1);
    chk("null_err",  64'(err_range), 64'd0);
    step();
    chk("range_msg",  64'(out_msg),   64'd0);
    chk("range_flag", 64'(out_null),  64'd1);
    chk("range_err",  64'(err_range), 64'd1);
    step();
    msg_valid = 1'b0;
    chk("k0_msg",  64'(out_msg),   64'hAABBCCDDEE);
    chk("k0_null", 64'(out_null),  64'd0);
    chk("k0_err",  64'(err_range), 64'd0);

`ifndef CYC_UNSHIFT_BYPASS_EN
    // Empty FIFO blocks messages
    msg_valid = 1'b1;
    #1 chk("empty_msg_ready", 64'(msg_ready), 64'd0);
    step();
    chk("empty_no_out", 64'(out_valid), 64'd0);
    msg_valid = 1'b0;
`else
    step();
`endif

    // Fill: 17 consecutive push attempts, tags k = i%5
    for (int i = 0; i < 17; i++) begin
      sh_valid = 1'b1;
      shift    = 8'((i % 5) << 2);
      if (i == 16) begin
        #1 chk("full_sh_ready", 64'(sh_ready), 64'd0);
      end
      step();
    end
    sh_valid = 1'b0;
    chk("full_cnt", 64'(fifo_cnt), 64'd16);

    // Backpressure: accept k=0 then hold 3 cycles
    out_ready = 1'b0; msg_valid = 1'b1; msg_in = 40'h0504030201;
    step();
    chk("bp_first", 64'(out_msg), 64'h0504030201);
    held = out_msg;
    for (int i = 0; i < 3; i++) begin
      #1 chk("bp_msg_ready", 64'(msg_ready), 64'd0);
      step();
      chk("bp_hold_msg",   64'(out_msg),   64'(held));
      chk("bp_hold_valid", 64'(out_valid), 64'd1);
    end
    chk("bp_cnt", 64'(fifo_cnt), 64'd15);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1 chk("drain_msg_ready", 64'(msg_ready), 64'd1);
      step();
      chk("drain_msg", 64'(out_msg), 64'(exp_drain[i]));
    end
    msg_valid = 1'b0;
    chk("drain_cnt", 64'(fifo_cnt), 64'd11);

    // Hold an output, then asynchronous reset mid-cycle
    out_ready = 1'b0; msg_valid = 1'b1;
    step();
    msg_valid = 1'b0;
    chk("pre_rst_valid", 64'(out_valid), 64'd1);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 64'(out_valid), 64'd0);
    chk("arst_cnt",       64'(fifo_cnt),  64'd0);
    chk("arst_msg",       64'(out_msg),   64'd0);
    #1 rst_n = 1'b1;
    step();
    out_ready = 1'b1; msg_valid = 1'b1;
    #1 chk("post_rst_msg_ready", 64'(msg_ready), 64'd0);
    step();
    chk("post_rst_no_out", 64'(out_valid), 64'd0);
    msg_valid = 1'b0;
    push_tag(8'h04);
    chk("post_rst_cnt1", 64'(fifo_cnt), 64'd1);

    // Simultaneous push and pop leaves the count unchanged
    sh_valid = 1'b1; shift = 8'h08; msg_valid = 1'b1; msg_in = 40'h0504030201;
    step();
    sh_valid = 1'b0;
    chk("pp_cnt", 64'(fifo_cnt), 64'd1);
    chk("pp_msg", 64'(out_msg),  64'h0403020105);
    step();
    msg_valid = 1'b0;
    chk("pp_msg2", 64'(out_msg),  64'h0302010504);
    chk("pp_cnt0", 64'(fifo_cnt), 64'd0);
    step();
    chk("idle_valid", 64'(out_valid), 64'd0);

`ifdef CYC_UNSHIFT_BYPASS_EN
    sh_valid = 1'b1; shift = 8'h04; msg_valid = 1'b1; msg_in = 40'h0504030201;
    #1;
    chk("byp_sh_ready",  64'(sh_ready),  64'd1);
    chk("byp_msg_ready", 64'(msg_ready), 64'd1);
    step();
    sh_valid = 1'b0; msg_valid = 1'b0;
    chk("byp_msg", 64'(out_msg),  64'h0403020105);
    chk("byp_cnt", 64'(fifo_cnt), 64'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
